// File: rtl/adc_sample_reader.sv
// Serial capture front end for an ADC128S022-class 8-channel, 12-bit converter.
// It runs back-to-back conversion frames while en is high and tags each result with its channel.
module adc_sample_reader #(
  parameter int CLK_DIV    = 25,
  parameter int GAP_CYCLES = 25
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        en,
  input  logic [2:0]  ch,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample,
  output logic [7:0]  sample8,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy
);

  localparam int CNT_MAX = ((CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES) + 1;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_bit;
  logic             r_high;
  logic [2:0]       r_curCh;
  logic [2:0]       r_prevCh;
  logic             r_sync1;
  logic             r_sync2;
  logic [11:0]      r_shift;
  logic             r_csN;
  logic             r_sclk;
  logic             r_din;
  logic [11:0]      r_sample;
  logic [7:0]       r_sample8;
  logic [2:0]       r_sampleCh;
  logic             r_valid;
  logic             r_busy;

  logic [3:0]       w_nextBit;
  logic             w_nextDin;

  assign w_nextBit = r_bit + 4'd1;

  // Address bits ADD2..ADD0 occupy bit slots 2..4 of the control word.
  always_comb begin
    w_nextDin = 1'b0;
    case (w_nextBit)
      4'd2:    w_nextDin = r_curCh[2];
      4'd3:    w_nextDin = r_curCh[1];
      4'd4:    w_nextDin = r_curCh[0];
      default: w_nextDin = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_high     <= 1'b0;
      r_curCh    <= '0;
      r_prevCh   <= '0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_shift    <= '0;
      r_csN      <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
      r_sample   <= '0;
      r_sample8  <= '0;
      r_sampleCh <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_sync1 <= adc_dout;
      r_sync2 <= r_sync1;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          r_csN  <= 1'b1;
          r_sclk <= 1'b1;
          r_din  <= 1'b0;
          r_busy <= 1'b0;
          if (en) begin
            r_curCh <= ch;
            r_csN   <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_state <= SETUP;
          end
        end
        SETUP: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_high  <= 1'b0;
            r_sclk  <= 1'b0;
            r_din   <= 1'b0;
            r_state <= SHIFT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt != DIV_LAST) begin
            r_cnt <= r_cnt + 1'b1;
          end else begin
            r_cnt <= '0;
            if (!r_high) begin
              r_high <= 1'b1;
              r_sclk <= 1'b1;
            end else begin
              // Only a 12-bit window is kept; the four leading zeros fall off the top.
              r_shift <= {r_shift[10:0], r_sync2};
              r_high  <= 1'b0;
              if (r_bit == 4'd15) begin
                r_state <= HOLD;
              end else begin
                r_bit  <= w_nextBit;
                r_sclk <= 1'b0;
                r_din  <= w_nextDin;
              end
            end
          end
        end
        HOLD: begin
          if (r_cnt == DIV_LAST) begin
            r_cnt      <= '0;
            r_csN      <= 1'b1;
            r_din      <= 1'b0;
            r_sample   <= r_shift;
            r_sample8  <= r_shift[11:4];
            r_sampleCh <= r_prevCh;
            r_prevCh   <= r_curCh;
            r_valid    <= 1'b1;
            r_state    <= GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          // The valid cycle plus GAP_CYCLES more keep CS_n high before the next frame.
          if (r_cnt == GAP_LAST) begin
            r_cnt <= '0;
            if (en) begin
              r_curCh <= ch;
              r_csN   <= 1'b0;
              r_state <= SETUP;
            end else begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign adc_cs_n     = r_csN;
  assign adc_sclk     = r_sclk;
  assign adc_din      = r_din;
  assign sample       = r_sample;
  assign sample8      = r_sample8;
  assign sample_ch    = r_sampleCh;
  assign sample_valid = r_valid;
  assign busy         = r_busy;

endmodule

// File: tb/tb_adc_sample_reader.sv
// Testbench for adc_sample_reader: a behavioural ADC model on the serial pins,
// a table of single-frame vectors and hand-written multi-frame sequences.
module tb_adc_sample_reader;

  localparam int DIV    = 4;
  localparam int GAPC   = 5;
  localparam int FRAME  = 34 * DIV;
  localparam int PERIOD = 34 * DIV + GAPC + 1;

  logic        sysClk = 1'b0;
  logic        sysRst = 1'b1;
  logic        en = 1'b0;
  logic [2:0]  ch = 3'd0;
  logic        adcCsN;
  logic        adcSclk;
  logic        adcDin;
  logic        adcDout = 1'b0;
  logic [11:0] sample;
  logic [7:0]  sample8;
  logic [2:0]  sampleCh;
  logic        sampleValid;
  logic        busy;

  int checks = 0;
  int failures = 0;

  adc_sample_reader #(.CLK_DIV(DIV), .GAP_CYCLES(GAPC)) dut (
    .sys_clk(sysClk), .sys_rst(sysRst), .en(en), .ch(ch),
    .adc_cs_n(adcCsN), .adc_sclk(adcSclk), .adc_din(adcDin), .adc_dout(adcDout),
    .sample(sample), .sample8(sample8), .sample_ch(sampleCh),
    .sample_valid(sampleValid), .busy(busy)
  );

  always #5 sysClk = ~sysClk;

  // ADC model: mode 0 returns fixedVal, mode 1 echoes previous address x 0x111, mode 2 walks sineTab.
  int          modelMode = 0;
  logic [11:0] fixedVal = 12'h000;
  logic [2:0]  modelPrevAddr = 3'd0;
  logic [15:0] curWord = 16'h0;
  logic [15:0] dinBits = 16'h0;
  logic [2:0]  lastAddr = 3'd0;
  int          fallCnt = 0;
  int          riseCnt = 0;
  int          fallsAtEnd = 0;
  int          sineIdx = 0;
  logic [7:0]  sineTab [8];

  always @(negedge adcCsN) begin
    fallCnt = 0;
    riseCnt = 0;
    dinBits = 16'h0;
    adcDout = 1'b0;
    case (modelMode)
      1: curWord = {4'h0, 1'b0, modelPrevAddr, 1'b0, modelPrevAddr, 1'b0, modelPrevAddr};
      2: begin
        curWord = {4'h0, sineTab[sineIdx % 8], 4'h0};
        sineIdx++;
      end
      default: curWord = {4'h0, fixedVal};
    endcase
  end

  always @(negedge adcSclk) begin
    if (adcCsN === 1'b0) begin
      if (fallCnt < 16) adcDout = curWord[15 - fallCnt];
      fallCnt++;
    end
  end

  always @(posedge adcSclk) begin
    if (adcCsN === 1'b0) begin
      if (riseCnt < 16) dinBits[riseCnt] = adcDin;
      riseCnt++;
    end
  end

  always @(posedge adcCsN) begin
    fallsAtEnd = fallCnt;
    lastAddr = {dinBits[2], dinBits[3], dinBits[4]};
    modelPrevAddr = lastAddr;
  end

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] adcVal;
    logic [11:0] expSample;
    logic [7:0]  expSample8;
    logic [2:0]  expCh;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic waitValid(output int cycles);
    cycles = 0;
    do begin
      @(negedge sysClk);
      cycles++;
    end while (sampleValid !== 1'b1 && cycles < 1000);
    if (sampleValid !== 1'b1) checkOutput("validTimeout", 0, 1);
  endtask

  task automatic waitIdle();
    int cycles = 0;
    while (busy !== 1'b0 && cycles < 100) begin
      @(negedge sysClk);
      cycles++;
    end
    checkOutput("idleReached", busy, 0);
    checkOutput("idleCsN", adcCsN, 1);
  endtask

  task automatic resetDut();
    sysRst = 1'b1;
    en = 1'b0;
    repeat (3) @(negedge sysClk);
    sysRst = 1'b0;
    modelPrevAddr = 3'd0;
    @(negedge sysClk);
  endtask

  task automatic applyStimulus(input vec_t v);
    int cycles;
    modelMode = 0;
    fixedVal = v.adcVal;
    ch = v.ch;
    en = 1'b1;
    @(negedge sysClk);
    en = 1'b0;
    checkOutput("vecCsFall", adcCsN, 0);
    checkOutput("vecBusyRise", busy, 1);
    waitValid(cycles);
    checkOutput("vecFrameLen", cycles, FRAME);
    checkOutput("vecCsAtValid", adcCsN, 1);
    checkOutput("vecSample", sample, v.expSample);
    checkOutput("vecSample8", sample8, v.expSample8);
    checkOutput("vecSampleCh", sampleCh, v.expCh);
    checkOutput("vecSclkFalls", fallsAtEnd, 16);
    checkOutput("vecAddr", lastAddr, v.ch);
    checkOutput("vecDinOther", dinBits & 16'hFFE3, 0);
    @(negedge sysClk);
    checkOutput("vecValidPulse", sampleValid, 0);
    waitIdle();
  endtask

  initial begin
    int cycles;
    int csLowSeen;

    sineTab[0] = 8'h80; sineTab[1] = 8'hDA; sineTab[2] = 8'hFF; sineTab[3] = 8'hDA;
    sineTab[4] = 8'h80; sineTab[5] = 8'h26; sineTab[6] = 8'h00; sineTab[7] = 8'h26;

    vecs[0] = '{3'd5, 12'hABC, 12'hABC, 8'hAB, 3'd0};
    vecs[1] = '{3'd2, 12'h000, 12'h000, 8'h00, 3'd5};
    vecs[2] = '{3'd7, 12'hFFF, 12'hFFF, 8'hFF, 3'd2};
    vecs[3] = '{3'd0, 12'h801, 12'h801, 8'h80, 3'd7};
    vecs[4] = '{3'd3, 12'h7FE, 12'h7FE, 8'h7F, 3'd0};

    // Reset values
    repeat (2) @(negedge sysClk);
    checkOutput("rstCsN", adcCsN, 1);
    checkOutput("rstSclk", adcSclk, 1);
    checkOutput("rstDin", adcDin, 0);
    checkOutput("rstValid", sampleValid, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSample", sample, 0);
    checkOutput("rstSample8", sample8, 0);
    checkOutput("rstSampleCh", sampleCh, 0);
    sysRst = 1'b0;
    repeat (3) @(negedge sysClk);
    checkOutput("idleNoEnCsN", adcCsN, 1);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Back-to-back frames with channel pipelining
    resetDut();
    modelMode = 1;
    ch = 3'd3;
    en = 1'b1;
    @(negedge sysClk);
    checkOutput("b2bCsFall", adcCsN, 0);
    ch = 3'd6;
    waitValid(cycles);
    checkOutput("b2bLen0", cycles, FRAME);
    checkOutput("b2bCh0", sampleCh, 0);
    checkOutput("b2bSample0", sample, 12'h000);
    checkOutput("b2bAddr0", lastAddr, 3);
    waitValid(cycles);
    checkOutput("b2bPeriod1", cycles, PERIOD);
    checkOutput("b2bCh1", sampleCh, 3);
    checkOutput("b2bSample1", sample, 12'h333);
    checkOutput("b2bAddr1", lastAddr, 6);
    waitValid(cycles);
    en = 1'b0;
    checkOutput("b2bPeriod2", cycles, PERIOD);
    checkOutput("b2bCh2", sampleCh, 6);
    checkOutput("b2bSample2", sample, 12'h666);
    waitIdle();

    // ch scrambled every cycle and en dropped around bit 10
    resetDut();
    modelMode = 0;
    fixedVal = 12'h3C9;
    ch = 3'd1;
    en = 1'b1;
    @(negedge sysClk);
    cycles = 0;
    do begin
      @(negedge sysClk);
      cycles++;
      ch = 3'($urandom_range(0, 7));
      if (cycles == 87) en = 1'b0;
    end while (sampleValid !== 1'b1 && cycles < 1000);
    checkOutput("dropValid", sampleValid, 1);
    checkOutput("dropFrameLen", cycles, FRAME);
    checkOutput("dropAddr", lastAddr, 1);
    checkOutput("dropSample", sample, 12'h3C9);
    checkOutput("dropSampleCh", sampleCh, 0);
    en = 1'b0;
    csLowSeen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge sysClk);
      if (adcCsN !== 1'b1) csLowSeen++;
    end
    checkOutput("dropNoNewFrame", csLowSeen, 0);
    checkOutput("dropBusy", busy, 0);

    // Reset asserted during SHIFT bit 7
    resetDut();
    fixedVal = 12'h5A5;
    ch = 3'd2;
    en = 1'b1;
    @(negedge sysClk);
    en = 1'b0;
    repeat (63) @(negedge sysClk);
    checkOutput("midCsLow", adcCsN, 0);
    #2 sysRst = 1'b1;
    #1;
    checkOutput("midRstCsN", adcCsN, 1);
    checkOutput("midRstSclk", adcSclk, 1);
    checkOutput("midRstDin", adcDin, 0);
    checkOutput("midRstValid", sampleValid, 0);
    checkOutput("midRstBusy", busy, 0);
    @(negedge sysClk);
    en = 1'b1;
    ch = 3'd6;
    @(negedge sysClk);
    sysRst = 1'b0;
    modelPrevAddr = 3'd0;
    @(negedge sysClk);
    en = 1'b0;
    checkOutput("postRstCsFall", adcCsN, 0);
    waitValid(cycles);
    checkOutput("postRstLen", cycles, FRAME);
    checkOutput("postRstFalls", fallsAtEnd, 16);
    checkOutput("postRstSample", sample, 12'h5A5);
    checkOutput("postRstCh", sampleCh, 0);
    checkOutput("postRstAddr", lastAddr, 6);
    waitIdle();

    // Sine ramp table, codes scaled by 16
    resetDut();
    modelMode = 2;
    sineIdx = 0;
    ch = 3'd4;
    en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      waitValid(cycles);
      if (k == 7) en = 1'b0;
      checkOutput($sformatf("sine8_%0d", k), sample8, sineTab[k]);
      checkOutput($sformatf("sine12_%0d", k), sample, {sineTab[k], 4'h0});
    end
    waitIdle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
